bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter using iterative double-dabble, one bit per clock. It sits directly upstream of the four-digit seven-segment scan decoder. It turns a binary count (stopwatch, frequency counter, etc.) into the `thousand`/`hundred`/`ten`/`one` BCD digits that the decoder multiplexes onto the display. Results are registered and held stable between conversions so the display never shows intermediate values.

## Interface
- `WIDTH`, 14, binary input width; conversion latency equals `WIDTH` cycles.
- `MAX_VAL`, 9999, largest displayable value; larger inputs flag overflow.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `bin` in WIDTH: binary value to convert; sampled only on an accepted `start`.
- `start` in 1: request a conversion; accepted only in IDLE.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when new digits are loaded.
- `overflow` out 1: high if the last converted value was greater than `MAX_VAL`; held until the next load.
- `thousand` out 4: BCD digit.
- `hundred` out 4: BCD digit.
- `ten` out 4: BCD digit.
- `one` out 4: BCD digit.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: runs exactly `WIDTH` iterations.
- IDLE with `start`=1:
  - Capture `bin` into the shift register and clear the 16-bit BCD scratch.
  - Clear the iteration counter.
  - Latch `ovf_pend = (bin > MAX_VAL)`.
  - Go to SHIFT.
- SHIFT, each cycle:
  - Every scratch nibble ≥5 gets +3.
  - Then {scratch, shift register} shifts left 1, with the shift-register MSB entering scratch bit 0.
  - The counter increments.
- On the final iteration (counter = `WIDTH`-1):
  - Load the output digits from the post-shift scratch value.
  - If `ovf_pend` is set, load all four digits with 4'hF, which the downstream decoder displays as blank, and set `overflow`=1.
  - Otherwise set `overflow`=0.
  - Pulse `done` and return to IDLE.
- Input range: inputs from 10000 to 2^WIDTH−1 may corrupt the thousands nibble of the scratch. This is harmless because the overflow path overrides the loaded digits.
- `start` while in SHIFT is ignored. No queuing; `bin` changes during SHIFT have no effect.
- Output digits, `overflow` and `done` change only at a load. Between loads they hold the previous result.
- Reset mid-conversion:
  - The conversion is abandoned.
  - All outputs return to reset values and the state returns to IDLE.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `overflow`=0.
  - All digits 4'd0, state IDLE, counter 0.
- `start` sampled high at edge N:
  - `busy`=1 from edge N until edge N+WIDTH.
  - Iterations occur at edges N+1 … N+WIDTH.
  - Digits and `done`=1 are valid from edge N+WIDTH; `busy` drops at the same edge.
  - `done` returns to 0 at edge N+WIDTH+1.
- Latency is `WIDTH` cycles from the accepting edge to valid digits: 14 with defaults. Throughput is one conversion per `WIDTH`+1 cycles.
- Back-to-back: `start` high in the cycle where `done`=1 is accepted, since the state is already IDLE. The next load occurs `WIDTH` edges later.
- `busy` and `done` are never high in the same cycle.

## Structure
- The shared display package holds:
  - `DIGITS`=4
  - `BCD_BLANK`=4'hF
  - `MAX_VAL`
  - the state enum {IDLE, SHIFT}
- Sub-module `bcd_adj3`: combinational nibble correction (out = in≥5 ? in+3 : in). It is instantiated four times on the scratch nibbles.
- The FSM, counter and output registers live in `bin2bcd_seq`. The counter width is $clog2(WIDTH).

## Test plan
- Reset, then `start` with `bin`=0 → after 14 cycles `done` pulses once; digits 0,0,0,0; `overflow`=0; `busy` high for exactly 14 cycles.
- `bin`=1234 → digits 1,2,3,4 at exactly edge N+14; outputs unchanged before that edge.
- `bin`=9999, then `bin`=10000 → first load gives 9,9,9,9 with `overflow`=0; second gives F,F,F,F with `overflow`=1.
- `start` held high continuously with `bin`=0x0FFF (4095) → loads every 15 cycles, each giving 4,0,9,5. Pulses of `start` during `busy` produce no extra `done`.
- `bin` changed from 42 to 7777 mid-conversion → result is 0,0,4,2.
- Assert `rst` at cycle 7 of a conversion after a prior result of 5,6,7,8 → all digits 0, `busy`=0, no `done`. A new `start` after release converts normally.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared display definitions for the binary-to-BCD converter and the downstream scan decoder.
// Holds digit count, blank code, displayable limit and the converter state encoding.
package bin2bcd_seq_pkg;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned BCD_W     = DIGITS * 4;
  localparam logic [3:0]  BCD_BLANK = 4'hF;
  localparam int unsigned MAX_VAL   = 9999;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef struct packed {
    logic [3:0] thousand;
    logic [3:0] hundred;
    logic [3:0] ten;
    logic [3:0] one;
  } bcd_t;

  // Every digit set to the blank code; the decoder shows nothing for it.
  function automatic bcd_t bcd_blank();
    bcd_t b;
    b.thousand = BCD_BLANK;
    b.hundred  = BCD_BLANK;
    b.ten      = BCD_BLANK;
    b.one      = BCD_BLANK;
    return b;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary source and the BCD converter.
// The master drives the request; the slave (converter) drives status and digits.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH = 14
);

  logic [WIDTH-1:0] bin;
  logic             start;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       thousand;
  logic [3:0]       hundred;
  logic [3:0]       ten;
  logic [3:0]       one;

  modport master (
    output bin,
    output start,
    input  busy,
    input  done,
    input  overflow,
    input  thousand,
    input  hundred,
    input  ten,
    input  one
  );

  modport slave (
    input  bin,
    input  start,
    output busy,
    output done,
    output overflow,
    output thousand,
    output hundred,
    output ten,
    output one
  );

endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more before the shift.
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock, with registered result digits
// that hold between conversions so the display never sees intermediate values.
module bin2bcd_seq #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned MAX_VAL = bin2bcd_seq_pkg::MAX_VAL
) (
  input logic             clk,
  input logic             rst,
  bin2bcd_seq_if.slave    bus
);

  import bin2bcd_seq_pkg::*;

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic               ovf_pend_q, ovf_pend_d;
  bcd_t               digits_q, digits_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               last_iter;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (scratch_q[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  // Corrected scratch and the binary shift register move as one long register.
  assign shifted   = {adj, sreg_q} << 1;
  assign last_iter = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    scratch_d  = scratch_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d     = bus.bin;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (32'(bus.bin) > MAX_VAL);
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        scratch_d = shifted[BCD_W+WIDTH-1:WIDTH];
        sreg_d    = shifted[WIDTH-1:0];
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_iter) begin
          // Out-of-range values may have corrupted the thousands nibble; blank them instead.
          digits_d   = ovf_pend_q ? bcd_blank() : bcd_t'(shifted[BCD_W+WIDTH-1:WIDTH]);
          overflow_d = ovf_pend_q;
          done_d     = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sreg_q     <= '0;
      scratch_q  <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      scratch_q  <= scratch_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.thousand = digits_q.thousand;
  assign bus.hundred  = digits_q.hundred;
  assign bus.ten      = digits_q.ten;
  assign bus.one      = digits_q.one;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: latency, hold, overflow, back-to-back,
// ignored restarts, mid-conversion input changes and asynchronous reset.
module tb_bin2bcd_seq;

  localparam int unsigned WIDTH = 14;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [15:0] exp_prev;
  int   nd;

  bin2bcd_seq_if #(.WIDTH(WIDTH)) bus ();

  bin2bcd_seq #(
    .WIDTH   (WIDTH),
    .MAX_VAL (9999)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {bus.thousand, bus.hundred, bus.ten, bus.one};
  endfunction

  always @(negedge clk) begin
    if (rst) check("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
  end

  // One conversion from an idle state; checks hold, latency, busy length and single done.
  task automatic convert(input string tag, input logic [13:0] val, input logic [15:0] exp_dig,
                         input logic exp_ovf);
    int busy_cyc;
    int done_cnt;
    int done_edge;
    @(negedge clk);
    bus.bin   = val;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_cyc  = 0;
    done_cnt  = 0;
    done_edge = -1;
    for (int e = 1; e <= int'(WIDTH) + 3; e++) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      if (e == int'(WIDTH) - 1) check({tag, ":hold"}, 32'(digits()), 32'(exp_prev));
      if (e == int'(WIDTH)) begin
        check({tag, ":digits"}, 32'(digits()), 32'(exp_dig));
        check({tag, ":overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        check({tag, ":busy_low"}, 32'(bus.busy), 32'd0);
      end
    end
    check({tag, ":busy_cycles"}, 32'(busy_cyc), 32'(WIDTH));
    check({tag, ":done_edge"}, 32'(done_edge), 32'(WIDTH));
    check({tag, ":done_count"}, 32'(done_cnt), 32'd1);
    exp_prev = exp_dig;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_prev  = 16'h0000;
    rst       = 1'b0;
    bus.bin   = '0;
    bus.start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", 32'(bus.busy), 32'd0);
    check("rst:done", 32'(bus.done), 32'd0);
    check("rst:overflow", 32'(bus.overflow), 32'd0);
    check("rst:digits", 32'(digits()), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    convert("zero", 14'd0, 16'h0000, 1'b0);
    convert("v1234", 14'd1234, 16'h1234, 1'b0);
    convert("v9999", 14'd9999, 16'h9999, 1'b0);
    convert("v10000", 14'd10000, 16'hFFFF, 1'b1);

    // start held high: loads at edges 14, 29, 44 after the first accept
    @(negedge clk);
    bus.bin   = 14'd4095;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    nd = 0;
    for (int e = 1; e <= 46; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        nd++;
        check("cont:edge", 32'(e), 32'(15 * nd - 1));
        check("cont:digits", 32'(digits()), 32'h4095);
        check("cont:overflow", 32'(bus.overflow), 32'd0);
      end
      if (e == 44) bus.start = 1'b0;
    end
    check("cont:count", 32'(nd), 32'd3);
    check("cont:idle", 32'(bus.busy), 32'd0);

    // bin changes and start pulses during SHIFT must not disturb the conversion of 42
    @(negedge clk);
    bus.bin   = 14'd42;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    nd = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 3) begin
        bus.bin   = 14'd7777;
        bus.start = 1'b1;
      end
      if (e == 4) bus.start = 1'b0;
      if (e == 8) bus.start = 1'b1;
      if (e == 9) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done) begin
        nd++;
        check("mid:edge", 32'(e), 32'(WIDTH));
        check("mid:digits", 32'(digits()), 32'h0042);
      end
    end
    check("mid:count", 32'(nd), 32'd1);
    exp_prev = 16'h0042;

    convert("v5678", 14'd5678, 16'h5678, 1'b0);

    // reset asserted after the 7th iteration of a new conversion
    @(negedge clk);
    bus.bin   = 14'd1234;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst:busy", 32'(bus.busy), 32'd0);
    check("arst:done", 32'(bus.done), 32'd0);
    check("arst:overflow", 32'(bus.overflow), 32'd0);
    check("arst:digits", 32'(digits()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nd  = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    check("arst:no_done", 32'(nd), 32'd0);
    check("arst:idle", 32'(bus.busy), 32'd0);
    exp_prev = 16'h0000;

    convert("after_rst", 14'd321, 16'h0321, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
